// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states and port ids.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    function automatic state_t busy_state(input port_t p);
        return (p == PORT_D) ? ST_BUSY_D : ST_BUSY_IF;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Request eligibility, data-over-fetch priority and the data streak counter
// that forces a pending fetch through after MAX_DSTREAK data grants.
module mem_arb_pick #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
    input  logic if_req,
    input  logic if_valid,
    input  logic d_req,
    input  logic d_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int unsigned SW = $clog2(MAX_DSTREAK) + 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak;
    logic          if_elig;
    logic          d_elig;

    // A port completing this cycle sits out the edge so the core can move its address.
    always_comb begin
        if_elig  = if_req & ~if_valid;
        d_elig   = d_req & ~d_valid;
        grant_d  = arb_en & d_elig & ~(if_elig & (streak == STREAK_MAX));
        grant_if = arb_en & if_elig & ~grant_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_d && if_elig && (streak != STREAK_MAX)) begin
            streak <= streak + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and the
// MEM-stage data port, one access at a time over a fixed read latency.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 32,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          stall_if,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    state_t        state;
    state_t        state_next;
    port_t         grant_port;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [DW-1:0] acc_wdata;
    logic          grant_if;
    logic          grant_d;
    logic          last_beat;

    mem_arb_pick #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_pick (
        .clock    (clock),
        .reset    (reset),
        .arb_en   (state == ST_IDLE),
        .if_req   (if_req),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_valid  (d_valid),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        grant_port = grant_d ? PORT_D : PORT_IF;
        last_beat  = (cnt == CNT_LAST);
        case (state)
            ST_IDLE: begin
                if (grant_d || grant_if) state_next = busy_state(grant_port);
            end
            ST_BUSY_IF, ST_BUSY_D: begin
                mem_en = 1'b1;
                // Strobe only on the first busy cycle so a write lands exactly once.
                mem_we = acc_we && (cnt == '0);
                if (last_beat) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc_addr  <= '0;
            acc_we    <= 1'b0;
            acc_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (grant_d) begin
                    acc_addr  <= d_addr;
                    acc_we    <= d_we;
                    acc_wdata <= d_wdata;
                end else if (grant_if) begin
                    acc_addr <= if_addr;
                    acc_we   <= 1'b0;
                end
            end else begin
                cnt <= cnt + CW'(1);
                if (last_beat) begin
                    if (state == ST_BUSY_IF) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end else begin
                        d_valid <= 1'b1;
                        if (!acc_we) d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h04:   return 32'h8C220000;
      8'h20:   return 32'h11112222;
      8'h21:   return 32'h33334444;
      default: return {24'hA5A5A5, a};
    endcase
  endfunction

  task automatic report_fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    fails++;
    $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0]  if_rdata;
    logic [31:0]  d_rdata;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         if_valid;
    logic         d_valid;
    logic         stall_if;
    logic         stall_mem;
    logic         mem_en;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [31:0]  mem [256];
    logic [255:0] written = '0;

    mem_port_arbiter #(
      .AW(8),
      .DW(32),
      .LATENCY(g + 1),
      .MAX_DSTREAK(4)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .stall_if  (stall_if),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .stall_mem (stall_mem),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    always @(posedge clock) begin
      if (mem_en && mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
    end

    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [47:0] seq;
  int unsigned nrec;
  logic        both;
  int unsigned nvalid;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1 reset = 1'b0;
    #2;
    tests++; if (g_dut[0].mem_en !== 1'b0) report_fail("rst mem_en", g_dut[0].mem_en, 1'b0);
    tests++; if (g_dut[0].mem_we !== 1'b0) report_fail("rst mem_we", g_dut[0].mem_we, 1'b0);
    tests++; if (g_dut[0].if_valid !== 1'b0) report_fail("rst if_valid", g_dut[0].if_valid, 1'b0);
    tests++; if (g_dut[0].d_valid !== 1'b0) report_fail("rst d_valid", g_dut[0].d_valid, 1'b0);
    tests++; if (g_dut[0].mem_addr !== 8'h00) report_fail("rst mem_addr", g_dut[0].mem_addr, 8'h00);
    tests++; if (g_dut[0].if_rdata !== 32'h0) report_fail("rst if_rdata", g_dut[0].if_rdata, 32'h0);
    tests++; if (g_dut[0].d_rdata !== 32'h0) report_fail("rst d_rdata", g_dut[0].d_rdata, 32'h0);
    tick; tick;
    reset = 1'b1;

    if_req = 1'b1; if_addr = 8'h04; #1;
    tests++; if (g_dut[0].stall_if !== 1'b1) report_fail("t2 c0 stall_if", g_dut[0].stall_if, 1'b1);
    tick;
    tests++; if (g_dut[0].stall_if !== 1'b1) report_fail("t2 c1 stall_if", g_dut[0].stall_if, 1'b1);
    tests++; if (g_dut[0].mem_en !== 1'b1) report_fail("t2 c1 mem_en", g_dut[0].mem_en, 1'b1);
    tests++; if (g_dut[0].mem_addr !== 8'h04) report_fail("t2 c1 mem_addr", g_dut[0].mem_addr, 8'h04);
    tests++; if (g_dut[0].if_valid !== 1'b0) report_fail("t2 c1 if_valid", g_dut[0].if_valid, 1'b0);
    tick;
    tests++; if (g_dut[0].if_valid !== 1'b1) report_fail("t2 c2 if_valid", g_dut[0].if_valid, 1'b1);
    tests++; if (g_dut[0].if_rdata !== 32'h8C220000) report_fail("t2 c2 if_rdata", g_dut[0].if_rdata, 32'h8C220000);
    tests++; if (g_dut[0].stall_if !== 1'b0) report_fail("t2 c2 stall_if", g_dut[0].stall_if, 1'b0);
    if_req = 1'b0;
    tick;
    tests++; if (g_dut[0].if_valid !== 1'b0) report_fail("t2 c3 if_valid", g_dut[0].if_valid, 1'b0);
    tests++; if (g_dut[0].mem_en !== 1'b0) report_fail("t2 c3 mem_en", g_dut[0].mem_en, 1'b0);
    repeat (4) tick;

    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF; #1;
    tests++; if (g_dut[1].mem_we !== 1'b0) report_fail("t3 c0 mem_we", g_dut[1].mem_we, 1'b0);
    tests++; if (g_dut[1].stall_mem !== 1'b1) report_fail("t3 c0 stall_mem", g_dut[1].stall_mem, 1'b1);
    tick;
    tests++; if (g_dut[1].mem_we !== 1'b1) report_fail("t3 c1 mem_we", g_dut[1].mem_we, 1'b1);
    tests++; if (g_dut[1].mem_addr !== 8'h10) report_fail("t3 c1 mem_addr", g_dut[1].mem_addr, 8'h10);
    tests++; if (g_dut[1].mem_wdata !== 32'hDEADBEEF) report_fail("t3 c1 mem_wdata", g_dut[1].mem_wdata, 32'hDEADBEEF);
    tick;
    tests++; if (g_dut[1].mem_we !== 1'b0) report_fail("t3 c2 mem_we", g_dut[1].mem_we, 1'b0);
    tests++; if (g_dut[1].mem_en !== 1'b1) report_fail("t3 c2 mem_en", g_dut[1].mem_en, 1'b1);
    tests++; if (g_dut[1].d_valid !== 1'b0) report_fail("t3 c2 d_valid", g_dut[1].d_valid, 1'b0);
    tick;
    tests++; if (g_dut[1].d_valid !== 1'b1) report_fail("t3 c3 d_valid", g_dut[1].d_valid, 1'b1);
    tests++; if (g_dut[1].d_rdata !== 32'h0) report_fail("t3 c3 d_rdata hold", g_dut[1].d_rdata, 32'h0);
    tests++; if (g_dut[1].stall_mem !== 1'b0) report_fail("t3 c3 stall_mem", g_dut[1].stall_mem, 1'b0);
    d_we = 1'b0;
    tick;
    tests++; if (g_dut[1].mem_en !== 1'b0) report_fail("t3 c4 dead mem_en", g_dut[1].mem_en, 1'b0);
    tick;
    tests++; if (g_dut[1].mem_en !== 1'b1) report_fail("t3 c5 mem_en", g_dut[1].mem_en, 1'b1);
    tests++; if (g_dut[1].mem_we !== 1'b0) report_fail("t3 c5 mem_we", g_dut[1].mem_we, 1'b0);
    tick;
    tests++; if (g_dut[1].d_valid !== 1'b0) report_fail("t3 c6 d_valid", g_dut[1].d_valid, 1'b0);
    tick;
    tests++; if (g_dut[1].d_valid !== 1'b1) report_fail("t3 c7 d_valid", g_dut[1].d_valid, 1'b1);
    tests++; if (g_dut[1].d_rdata !== 32'hDEADBEEF) report_fail("t3 c7 d_rdata", g_dut[1].d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    repeat (6) tick;

    d_we = 1'b0; d_addr = 8'h21; if_addr = 8'h04; d_req = 1'b1; if_req = 1'b1;
    seq = '0; nrec = 0; both = 1'b0;
    for (int unsigned c = 0; c < 60 && nrec < 6; c++) begin
      tick;
      if (g_dut[0].d_valid && g_dut[0].if_valid) both = 1'b1;
      if (g_dut[0].d_valid) begin
        seq = {seq[39:0], 8'h44};
        nrec++;
      end else if (g_dut[0].if_valid) begin
        seq = {seq[39:0], 8'h49};
        nrec++;
      end
      if_req = !g_dut[0].d_valid;
    end
    tests++; if (seq !== 48'h444444444944) report_fail("t4 grant order", seq, 48'h444444444944);
    tests++; if (both !== 1'b0) report_fail("t4 both valid", both, 1'b0);
    tests++; if (g_dut[0].d_rdata !== 32'h33334444) report_fail("t4 d_rdata", g_dut[0].d_rdata, 32'h33334444);
    d_req = 1'b0; if_req = 1'b0;
    repeat (8) tick;

    if_addr = 8'h04; if_req = 1'b1;
    tick;
    tests++; if (g_dut[0].mem_en !== 1'b1) report_fail("t5 c1 mem_en", g_dut[0].mem_en, 1'b1);
    tick;
    tests++; if (g_dut[0].if_valid !== 1'b1) report_fail("t5 c2 if_valid", g_dut[0].if_valid, 1'b1);
    tick;
    tests++; if (g_dut[0].if_valid !== 1'b0) report_fail("t5 c3 if_valid", g_dut[0].if_valid, 1'b0);
    tests++; if (g_dut[0].mem_en !== 1'b0) report_fail("t5 c3 dead mem_en", g_dut[0].mem_en, 1'b0);
    tick;
    tests++; if (g_dut[0].mem_en !== 1'b1) report_fail("t5 c4 mem_en", g_dut[0].mem_en, 1'b1);
    tick;
    tests++; if (g_dut[0].if_valid !== 1'b1) report_fail("t5 c5 if_valid", g_dut[0].if_valid, 1'b1);
    if_req = 1'b0;
    repeat (6) tick;

    d_we = 1'b0; d_addr = 8'h20; d_req = 1'b1;
    tick;
    tests++; if (g_dut[2].mem_addr !== 8'h20) report_fail("t6 c1 mem_addr", g_dut[2].mem_addr, 8'h20);
    d_addr = 8'h21;
    tick;
    tests++; if (g_dut[2].mem_addr !== 8'h20) report_fail("t6 c2 mem_addr", g_dut[2].mem_addr, 8'h20);
    tests++; if (g_dut[2].mem_en !== 1'b1) report_fail("t6 c2 mem_en", g_dut[2].mem_en, 1'b1);
    tick;
    tests++; if (g_dut[2].mem_addr !== 8'h20) report_fail("t6 c3 mem_addr", g_dut[2].mem_addr, 8'h20);
    tests++; if (g_dut[2].d_valid !== 1'b0) report_fail("t6 c3 d_valid", g_dut[2].d_valid, 1'b0);
    tick;
    tests++; if (g_dut[2].d_valid !== 1'b1) report_fail("t6 c4 d_valid", g_dut[2].d_valid, 1'b1);
    tests++; if (g_dut[2].d_rdata !== 32'h11112222) report_fail("t6 c4 d_rdata", g_dut[2].d_rdata, 32'h11112222);
    d_req = 1'b0;
    repeat (6) tick;

    d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
    tick;
    tests++; if (g_dut[1].mem_we !== 1'b1) report_fail("t1 busy mem_we", g_dut[1].mem_we, 1'b1);
    #2 reset = 1'b0; d_req = 1'b0;
    #1;
    tests++; if (g_dut[1].mem_en !== 1'b0) report_fail("t1 mem_en", g_dut[1].mem_en, 1'b0);
    tests++; if (g_dut[1].mem_we !== 1'b0) report_fail("t1 mem_we", g_dut[1].mem_we, 1'b0);
    tests++; if (g_dut[1].mem_addr !== 8'h00) report_fail("t1 mem_addr", g_dut[1].mem_addr, 8'h00);
    tests++; if (g_dut[1].mem_wdata !== 32'h0) report_fail("t1 mem_wdata", g_dut[1].mem_wdata, 32'h0);
    tests++; if (g_dut[1].d_valid !== 1'b0) report_fail("t1 d_valid", g_dut[1].d_valid, 1'b0);
    tests++; if (g_dut[1].d_rdata !== 32'h0) report_fail("t1 d_rdata", g_dut[1].d_rdata, 32'h0);
    tests++; if (g_dut[1].if_rdata !== 32'h0) report_fail("t1 if_rdata", g_dut[1].if_rdata, 32'h0);
    tests++; if (g_dut[1].stall_mem !== 1'b0) report_fail("t1 stall_mem", g_dut[1].stall_mem, 1'b0);
    tick; tick;
    reset = 1'b1;
    nvalid = 0;
    repeat (6) begin
      tick;
      if (g_dut[1].d_valid || g_dut[1].mem_en) nvalid++;
    end
    tests++; if (nvalid !== 0) report_fail("t1 no activity after reset", nvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

endmodule
